// File: rtl/instr_fetch_queue_if.sv
// Handshake bundle between fetch, the instruction queue and decode.
// master: the fetch/decode side driving requests; slave: the queue itself.
interface instr_fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             push;
  logic [29:0]      instr;
  logic [XLEN-1:0]  pushPc;
  logic             bufferFull;
  logic             pop;
  logic             valid;
  logic [31:0]      outInstr;
  logic [XLEN-1:0]  outPc;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, push, instr, pushPc, pop,
    input  bufferFull, valid, outInstr, outPc, count
  );

  modport slave (
    input  flush, push, instr, pushPc, pop,
    output bufferFull, valid, outInstr, outPc, count
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction queue between fetch and decode.
// Fetch pushes 30-bit compressed words (bits [31:2]) with their PC; decode sees
// the head in show-ahead order with the implied 2'b11 restored. bufferFull is
// fed back to fetch for clock gating. flush drops every entry on a redirect.
// Optional build macro: IFQ_BYPASS_EN -- when the queue is empty a pushed word
// is presented at the head in the same cycle, and if decode pops it in that
// cycle it never enters storage.
// DEPTH must be a power of two and at least 2.
module instr_fetch_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic               clockGate,
  input  logic               resetn,
  instr_fetch_queue_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]   wp_q, wp_d;
  logic [PW-1:0]   rp_q, rp_d;

  logic [29:0]     instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];

  logic            empty;
  logic            full;
  logic            byp_active;
  logic            byp_consume;
  logic            push_acc;
  logic            pop_acc;
  logic [29:0]     head_instr;
  logic [XLEN-1:0] head_pc;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);

`ifdef IFQ_BYPASS_EN
  // Empty queue forwards the incoming word straight to the head; a same-cycle
  // pop takes it and leaves both pointers where they are.
  assign byp_active  = empty & bus.push & ~bus.flush;
  assign byp_consume = byp_active & bus.pop;
`else
  assign byp_active  = 1'b0;
  assign byp_consume = 1'b0;
`endif

  // A push while full is dropped even when a pop frees a slot this cycle.
  assign push_acc = bus.push & ~full & ~bus.flush & ~byp_consume;
  assign pop_acc  = bus.pop & ~empty & ~bus.flush;

  assign head_instr = byp_active ? bus.instr  : instr_mem_q[rp_q[AW-1:0]];
  assign head_pc    = byp_active ? bus.pushPc : pc_mem_q[rp_q[AW-1:0]];

  assign bus.valid      = ~empty | byp_active;
  assign bus.outInstr   = {head_instr, 2'b11};
  assign bus.outPc      = head_pc;
  assign bus.bufferFull = full;
  assign bus.count      = wp_q - rp_q;

  // Pointer next-state: flush overrides any same-cycle push or pop.
  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (bus.flush) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      if (push_acc) wp_d = wp_q + PW'(1);
      if (pop_acc)  rp_d = rp_q + PW'(1);
    end
  end

  // Pointer registers, cleared asynchronously.
  always_ff @(posedge clockGate or negedge resetn) begin
    if (!resetn) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Entry storage; contents survive reset and flush since the pointers gate visibility.
  always_ff @(posedge clockGate) begin
    if (push_acc) begin
      instr_mem_q[wp_q[AW-1:0]] <= bus.instr;
      pc_mem_q[wp_q[AW-1:0]]    <= bus.pushPc;
    end
  end

endmodule
